// File: rtl/mxint_add_sub_seq.sv
`default_nettype none
// mxint_add_sub_seq: multi-cycle MXINT block adder/subtractor (align, LANES-wide add/sub, renormalise).
// Rev 1.0
module mxint_add_sub_seq #(
  parameter int ELEM_WIDTH  = 8,
  parameter int SCALE_WIDTH = 8,
  parameter int BLOCK_SIZE  = 32,
  parameter int LANES       = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic                             i_is_add,
  input  logic [SCALE_WIDTH-1:0]           i_scale_a,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] i_elements_a,
  input  logic [SCALE_WIDTH-1:0]           i_scale_b,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] i_elements_b,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [SCALE_WIDTH-1:0]           o_scale,
  output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] o_elements,
  output logic                             o_sat
);

  localparam int NBEATS  = BLOCK_SIZE / LANES;
  localparam int BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IDX_W   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int SUM_W   = ELEM_WIDTH + 1;
  localparam int SHAMT_W = (ELEM_WIDTH > 2) ? $clog2(ELEM_WIDTH) : 1;
  localparam int DATA_W  = BLOCK_SIZE * ELEM_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_NORM    = 2'd2;
  localparam logic [1:0] S_OUT     = 2'd3;

  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [SCALE_WIDTH-1:0] SCALE_NAN = {SCALE_WIDTH{1'b1}};
  localparam logic [SCALE_WIDTH-1:0] SCALE_SAT = {{(SCALE_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [SCALE_WIDTH-1:0] SHIFT_CAP = SCALE_WIDTH'(ELEM_WIDTH - 1);
  localparam logic [ELEM_WIDTH-1:0]  ELEM_MAX  = {1'b0, {(ELEM_WIDTH-1){1'b1}}};
  localparam logic [ELEM_WIDTH-1:0]  ELEM_MIN  = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic                   accept;
  logic                   beat_en;
  logic                   norm_en;
  logic                   done_out;

  logic [BEAT_W-1:0]      beat;
  logic                   ovf;
  logic [SCALE_WIDTH-1:0] scale_a;
  logic [SCALE_WIDTH-1:0] scale_b;
  logic [DATA_W-1:0]      elems_a;
  logic [DATA_W-1:0]      elems_b;
  logic                   is_add;

  logic                   a_ge_b;
  logic [SCALE_WIDTH-1:0] s_max;
  logic [SCALE_WIDTH-1:0] diff;
  logic [SHAMT_W-1:0]     shamt;
  logic                   nan;
  logic [SCALE_WIDTH-1:0] norm_scale;
  logic                   norm_sat;
  logic [DATA_W-1:0]      norm_elements;

  logic [ELEM_WIDTH-1:0]  elem_a  [BLOCK_SIZE];
  logic [ELEM_WIDTH-1:0]  elem_b  [BLOCK_SIZE];
  logic [SUM_W-1:0]       sum_buf [BLOCK_SIZE];
  logic [SUM_W-1:0]       lane_sum [LANES];
  logic [LANES-1:0]       lane_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = S_COMPUTE;
      S_COMPUTE: if (beat == LAST_BEAT) state_next = S_NORM;
      S_NORM:    state_next = S_OUT;
      S_OUT:     if (done_out) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    beat_en  = 1'b0;
    norm_en  = 1'b0;
    done_out = 1'b0;
    case (state)
      S_IDLE:    accept   = i_valid & o_ready;
      S_COMPUTE: beat_en  = 1'b1;
      S_NORM:    norm_en  = 1'b1;
      S_OUT:     done_out = o_valid & i_ready;
      default:   ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scale_a <= '0;
      scale_b <= '0;
      elems_a <= '0;
      elems_b <= '0;
      is_add  <= 1'b0;
    end else if (accept) begin
      scale_a <= i_scale_a;
      scale_b <= i_scale_b;
      elems_a <= i_elements_a;
      elems_b <= i_elements_b;
      is_add  <= i_is_add;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat <= '0;
      ovf  <= 1'b0;
    end else begin
      if (beat_en) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        ovf  <= ovf | (|lane_ovf);
      end
      if (done_out) ovf <= 1'b0;
    end
  end

  // Distances beyond ELEM_WIDTH-1 already leave only sign bits, so the shift is capped.
  always_comb begin
    a_ge_b = (scale_a >= scale_b);
    s_max  = a_ge_b ? scale_a : scale_b;
    diff   = a_ge_b ? (scale_a - scale_b) : (scale_b - scale_a);
    shamt  = (diff > SHIFT_CAP) ? SHAMT_W'(SHIFT_CAP) : SHAMT_W'(diff);
    nan    = (scale_a == SCALE_NAN) || (scale_b == SCALE_NAN);
    norm_sat = !nan && ovf && (s_max == SCALE_SAT);
    if (nan)                     norm_scale = SCALE_NAN;
    else if (!ovf)               norm_scale = s_max;
    else if (s_max != SCALE_SAT) norm_scale = s_max + 1'b1;
    else                         norm_scale = s_max;
  end

  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_unpack
    assign elem_a[k] = elems_a[k*ELEM_WIDTH +: ELEM_WIDTH];
    assign elem_b[k] = elems_b[k*ELEM_WIDTH +: ELEM_WIDTH];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0]             idx;
    logic signed [ELEM_WIDTH-1:0] a_raw;
    logic signed [ELEM_WIDTH-1:0] b_raw;
    logic signed [ELEM_WIDTH-1:0] a_al;
    logic signed [ELEM_WIDTH-1:0] b_al;
    logic signed [SUM_W-1:0]      a_ext;
    logic signed [SUM_W-1:0]      b_ext;

    assign idx   = IDX_W'(beat) * IDX_W'(LANES) + IDX_W'(l);
    assign a_raw = elem_a[idx];
    assign b_raw = elem_b[idx];
    assign a_al  = a_ge_b ? a_raw : (a_raw >>> shamt);
    assign b_al  = a_ge_b ? (b_raw >>> shamt) : b_raw;
    assign a_ext = {a_al[ELEM_WIDTH-1], a_al};
    assign b_ext = {b_al[ELEM_WIDTH-1], b_al};
    assign lane_sum[l] = is_add ? (a_ext + b_ext) : (a_ext - b_ext);
    assign lane_ovf[l] = lane_sum[l][ELEM_WIDTH] ^ lane_sum[l][ELEM_WIDTH-1];
  end

  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_elem
    localparam int                LANE    = k % LANES;
    localparam logic [BEAT_W-1:0] MY_BEAT = BEAT_W'(k / LANES);
    logic [ELEM_WIDTH-1:0] norm_el;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                         sum_buf[k] <= '0;
      else if (beat_en && beat == MY_BEAT)  sum_buf[k] <= lane_sum[LANE];
    end

    always_comb begin
      if (nan)
        norm_el = '0;
      else if (!ovf)
        norm_el = sum_buf[k][ELEM_WIDTH-1:0];
      else if (s_max != SCALE_SAT)
        norm_el = sum_buf[k][ELEM_WIDTH:1];
      else if (sum_buf[k][ELEM_WIDTH] != sum_buf[k][ELEM_WIDTH-1])
        norm_el = sum_buf[k][ELEM_WIDTH] ? ELEM_MIN : ELEM_MAX;
      else
        norm_el = sum_buf[k][ELEM_WIDTH-1:0];
    end

    assign norm_elements[k*ELEM_WIDTH +: ELEM_WIDTH] = norm_el;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_scale    <= '0;
      o_elements <= '0;
      o_sat      <= 1'b0;
      o_ready    <= 1'b0;
    end else begin
      if (norm_en) begin
        o_valid    <= 1'b1;
        o_scale    <= norm_scale;
        o_elements <= norm_elements;
        o_sat      <= norm_sat;
      end else if (done_out) begin
        o_valid    <= 1'b0;
      end
      if (accept)                            o_ready <= 1'b0;
      else if (state == S_IDLE || done_out)  o_ready <= 1'b1;
    end
  end

endmodule
`default_nettype wire
